// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Purpose  : Binary-to-BCD converter feeding a multiplexed 7-segment scanner.
// Revision : 1.0
// ============================================================================
module seg_display_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int BIN_WIDTH     = 16,
    parameter int REFRESH_BITS  = 17,
    parameter int BLANK_LEADING = 1,
    parameter int GHOST_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value_in,
    input  logic                  value_valid,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  ready,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [7:0]            an
);

    localparam int         BCD_DIGITS = (BIN_WIDTH + 2) / 3 + 1;
    localparam int         BCD_W      = BCD_DIGITS * 4;
    localparam logic [4:0] LAST_BIT   = 5'(BIN_WIDTH - 1);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    load_q, load_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [BIN_WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dp_lat_q, dp_lat_d;
    logic [NUM_DIGITS*4-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
    logic                    overflow_q, overflow_d;

    logic [BCD_W-1:0]        w_bcd_adj;
    logic [NUM_DIGITS*4-1:0] w_commit;
    logic                    w_ovf;

    logic [REFRESH_BITS-1:0] scan_cnt_q;
    logic [2:0]              idx_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [7:0]              an_q;

    logic                    w_on;
    logic [31:0]             w_disp8;
    logic [7:0]              w_dp8;
    logic [2:0]              w_msd;
    logic [3:0]              w_digit;
    logic [6:0]              w_seg;
    logic                    w_dp;
    logic [7:0]              w_an;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                w_ovf = 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_commit
            if (g < BCD_DIGITS) begin : g_bcd
                assign w_commit[g*4 +: 4] = bcd_q[g*4 +: 4];
            end else begin : g_zero
                assign w_commit[g*4 +: 4] = 4'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            shift_q    <= '0;
            bcd_q      <= '0;
            dp_lat_q   <= '0;
            disp_q     <= '0;
            dp_disp_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            dp_lat_q   <= dp_lat_d;
            disp_q     <= disp_d;
            dp_disp_q  <= dp_disp_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_d     = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        dp_lat_d   = dp_lat_q;
        disp_d     = disp_q;
        dp_disp_d  = dp_disp_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                // Value is captured on the strobe edge; conversion starts one edge later.
                if (load_q) begin
                    state_d   = S_CONVERT;
                    bit_cnt_d = 5'd0;
                    bcd_d     = '0;
                end else if (value_valid) begin
                    load_d   = 1'b1;
                    shift_d  = value_in;
                    dp_lat_d = dp_in;
                end
            end
            S_CONVERT: begin
                {bcd_d, shift_d} = {w_bcd_adj, shift_q} << 1;
                bit_cnt_d        = bit_cnt_q + 5'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d     = w_commit;
                dp_disp_d  = dp_lat_q;
                overflow_d = w_ovf;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready    = (state_q == S_IDLE) && !load_q;
    assign overflow = overflow_q;

    generate
        if (GHOST_CYCLES == 0) begin : g_ghost_none
            assign w_on = 1'b1;
        end else begin : g_ghost_cmp
            localparam logic [REFRESH_BITS-1:0] GHOST_C = REFRESH_BITS'(GHOST_CYCLES);
            assign w_on = (scan_cnt_q >= GHOST_C);
        end
    endgenerate

    assign w_disp8 = 32'(disp_q);
    assign w_dp8   = 8'(dp_disp_q);
    assign w_digit = w_disp8[{idx_q, 2'b00} +: 4];

    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_disp8[i*4 +: 4] != 4'd0) begin
                w_msd = 3'(i);
            end
        end
    end

    always_comb begin
        w_an = 8'hFF;
        if (w_on) begin
            w_an[idx_q] = 1'b0;
        end
        if (overflow_q) begin
            w_seg = SEG_DASH;
            w_dp  = 1'b1;
        end else begin
            w_seg = ((BLANK_LEADING != 0) && (idx_q > w_msd)) ? SEG_BLANK : dec7(w_digit);
            w_dp  = ~w_dp8[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= 3'd0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
            if (scan_cnt_q == '1) begin
                idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
            end
            seg_q <= w_seg;
            dp_q  <= w_dp;
            an_q  <= w_an;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_ctrl
// Purpose  : Scoreboard bench for seg_display_ctrl across three configurations.
// Revision : 1.0
// ============================================================================
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'd0;
    logic        value_valid = 1'b0;
    logic [7:0]  dp_in = 8'd0;

    logic       ready_a, ovf_a, dp_a, ready_b, ovf_b, dp_b, ready_c, ovf_c, dp_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [7:0] an_a, an_b, an_c;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    typedef struct {
        int         value;
        logic [7:0] dpm;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    seg_display_ctrl #(.NUM_DIGITS(8), .BIN_WIDTH(16), .REFRESH_BITS(4),
                       .BLANK_LEADING(1), .GHOST_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .dp_in(dp_in), .ready(ready_a), .overflow(ovf_a), .seg(seg_a), .dp(dp_a), .an(an_a));

    seg_display_ctrl #(.NUM_DIGITS(3), .BIN_WIDTH(16), .REFRESH_BITS(4),
                       .BLANK_LEADING(1), .GHOST_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .dp_in(dp_in[2:0]), .ready(ready_b), .overflow(ovf_b), .seg(seg_b), .dp(dp_b), .an(an_b));

    seg_display_ctrl #(.NUM_DIGITS(8), .BIN_WIDTH(16), .REFRESH_BITS(4),
                       .BLANK_LEADING(0), .GHOST_CYCLES(2)) u_dut_c (
        .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .dp_in(dp_in), .ready(ready_c), .overflow(ovf_c), .seg(seg_c), .dp(dp_c), .an(an_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic exp_ovf(input int v, input int nd);
        int lim = 1;
        for (int i = 0; i < nd; i++) lim *= 10;
        return (v >= lim);
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int nd, input int blank, input int k);
        int p = 1;
        if (exp_ovf(v, nd)) return 7'b0111111;
        for (int i = 0; i < k; i++) p *= 10;
        if (blank != 0 && k > 0 && v < p) return 7'h7F;
        return pat((v / p) % 10);
    endfunction

    function automatic logic exp_dp(input int v, input int nd, input logic [7:0] dpm, input int k);
        if (exp_ovf(v, nd)) return 1'b1;
        return ~dpm[k];
    endfunction

    function automatic int low_idx(input logic [7:0] a);
        int r = 0;
        for (int i = 0; i < 8; i++) if (!a[i]) r = i;
        return r;
    endfunction

    task automatic send(input int v, input logic [7:0] d);
        @(negedge clk);
        value_in    = 16'(v);
        dp_in       = d;
        value_valid = 1'b1;
        sb_q.push_back('{v, d});
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_ready(output int j);
        j = 0;
        while (ready_a !== 1'b1 && j < 60) begin
            @(negedge clk);
            j++;
        end
        check_val("B ready", ready_b, 1);
        check_val("C ready", ready_c, 1);
    endtask

    // Pops one expected value and walks every slot of all three scanners.
    task automatic check_display();
        exp_t       e;
        logic [7:0] ma = '0, mc = '0;
        logic [2:0] mb = '0;
        logic       one_ok = 1'b1, upper_ok = 1'b1;
        int         k;
        if (sb_q.size() == 0) begin
            check_val("scoreboard empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_val("A ovf", ovf_a, exp_ovf(e.value, 8));
        check_val("B ovf", ovf_b, exp_ovf(e.value, 3));
        check_val("C ovf", ovf_c, exp_ovf(e.value, 8));
        repeat (8 * 16 + 8) begin
            @(negedge clk);
            if (an_a != 8'hFF) begin
                k = low_idx(an_a);
                if ($countones(an_a) != 7) one_ok = 1'b0;
                if (!ma[k]) begin
                    ma[k] = 1'b1;
                    check_val($sformatf("A seg%0d v%0d", k, e.value), seg_a, exp_seg(e.value, 8, 1, k));
                    check_val($sformatf("A dp%0d v%0d", k, e.value), dp_a, exp_dp(e.value, 8, e.dpm, k));
                end
            end
            if (an_b[7:3] != 5'h1F) upper_ok = 1'b0;
            if (an_b != 8'hFF) begin
                k = low_idx(an_b);
                if ($countones(an_b) != 7) one_ok = 1'b0;
                if (k < 3 && !mb[k]) begin
                    mb[k] = 1'b1;
                    check_val($sformatf("B seg%0d v%0d", k, e.value), seg_b, exp_seg(e.value, 3, 1, k));
                    check_val($sformatf("B dp%0d v%0d", k, e.value), dp_b, exp_dp(e.value, 3, e.dpm, k));
                end
            end
            if (an_c != 8'hFF) begin
                k = low_idx(an_c);
                if ($countones(an_c) != 7) one_ok = 1'b0;
                if (!mc[k]) begin
                    mc[k] = 1'b1;
                    check_val($sformatf("C seg%0d v%0d", k, e.value), seg_c, exp_seg(e.value, 8, 0, k));
                end
            end
        end
        check_val("A slots seen", ma, 8'hFF);
        check_val("B slots seen", mb, 3'h7);
        check_val("C slots seen", mc, 8'hFF);
        check_val("one anode low", one_ok, 1);
        check_val("B an[7:3] high", upper_ok, 1);
    endtask

    task automatic ghost_scan();
        int   lo[8];
        int   last_k = -1;
        int   k;
        logic one_ok = 1'b1;
        foreach (lo[i]) lo[i] = 0;
        repeat (128) begin
            @(negedge clk);
            if (an_a != 8'hFF) begin
                if ($countones(an_a) != 7) one_ok = 1'b0;
                k = low_idx(an_a);
                lo[k]++;
                if (last_k >= 0 && k != last_k)
                    check_val("A index step", k, (last_k + 1) % 8);
                last_k = k;
            end
        end
        for (int i = 0; i < 8; i++)
            check_val($sformatf("A on-cycles an%0d", i), lo[i], 14);
        check_val("A single anode", one_ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " an"}, an_a, 8'hFF);
        check_val({tag, " seg"}, seg_a, 7'h7F);
        check_val({tag, " dp"}, dp_a, 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst");
        end
        check_val("rst ready", ready_a, 1);
        check_val("rst ovf", ovf_a, 0);
        reset = 1'b0;
        sb_q.push_back('{0, 8'h00});
        check_display();

        send(359, 8'h00);
        wait_ready(lat);
        check_val("latency 359", lat, 18);
        check_display();

        send(0, 8'hA5);
        wait_ready(lat);
        check_display();

        send(1000, 8'h07);
        wait_ready(lat);
        check_display();

        send(65535, 8'h12);
        wait_ready(lat);
        check_val("latency 65535", lat, 18);
        check_display();

        // Second strobe while busy must be dropped.
        @(negedge clk);
        value_in    = 16'd123;
        dp_in       = 8'h00;
        value_valid = 1'b1;
        sb_q.push_back('{123, 8'h00});
        @(negedge clk);
        value_valid = 1'b0;
        lat = 0;
        while (ready_a !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                value_in    = 16'd456;
                value_valid = 1'b1;
                check_val("busy ready", ready_a, 0);
            end else if (lat == 5) begin
                value_valid = 1'b0;
            end
        end
        value_valid = 1'b0;
        check_val("latency 123", lat, 18);
        check_display();

        ghost_scan();

        send(999, 8'hFF);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("abort");
        end
        reset = 1'b0;
        check_val("abort ready", ready_a, 1);
        check_val("abort ovf", ovf_a, 0);
        sb_q.delete();
        sb_q.push_back('{0, 8'h00});
        repeat (30) @(negedge clk);
        check_display();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of scanned digits, legal range 1..8.
REQ-002 Parameter BIN_WIDTH, default 16, width of the unsigned binary input, legal range 4..27.
REQ-003 Parameter REFRESH_BITS, default 17, width of the per-digit dwell counter (dwell = 2^REFRESH_BITS clk cycles).
REQ-004 Parameter BLANK_LEADING, default 1, where 1 blanks leading zeros and 0 shows all digits.
REQ-005 Parameter GHOST_CYCLES, default 16, anode-off guard cycles at the start of each digit slot, legal range 0..2^REFRESH_BITS-1.
REQ-006 clk  input  1  system clock (100 MHz); single clock domain.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 value_in  input  BIN_WIDTH  unsigned binary value to display.
REQ-009 value_valid  input  1  load strobe, accepted only when ready=1.
REQ-010 dp_in  input  NUM_DIGITS  decimal-point enables, bit i for digit i; sampled with value_in.
REQ-011 ready  output  1  high when a new value can be accepted.
REQ-012 overflow  output  1  high while the displayed value exceeds the capacity of NUM_DIGITS digits.
REQ-013 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 dp  output  1  active-low decimal point.
REQ-015 an  output  8  active-low anodes; an[0] is the least significant digit.

Function
REQ-016 FSM states: IDLE, CONVERT, COMMIT; reset enters IDLE.
REQ-017 IDLE: ready=1; value_valid=1 latches value_in and dp_in, and the FSM moves to CONVERT on the next edge.
REQ-018 CONVERT: sequential double-dabble, one bit per cycle, exactly BIN_WIDTH cycles; ready=0; value_valid is ignored (no queuing).
REQ-019 Internal BCD register: ceil(BIN_WIDTH/3)+1 digits wide, so the conversion never truncates.
REQ-020 COMMIT: one cycle; copies the low NUM_DIGITS BCD digits and the latched dp bits into the display register; sets overflow=1 if any BCD digit at position >= NUM_DIGITS is nonzero, otherwise 0; returns to IDLE.
REQ-021 Latency: with value_valid accepted at edge N, the display register and overflow update at edge N+BIN_WIDTH+2, and ready=1 again from that edge.
REQ-022 Scan counter: free-running, REFRESH_BITS wide; the digit index increments when the counter wraps to 0, and the index wraps from NUM_DIGITS-1 to 0.
REQ-023 Active anode: an[index]=0 only when the scan counter is >= GHOST_CYCLES; all other anode bits are 1.
REQ-024 an[7:NUM_DIGITS] are held at 1 at all times.
REQ-025 Segment decode: 0-9 use standard patterns; an overflow condition shows a dash (7'b0111111) on every scanned digit, with dp=1.
REQ-026 Leading blanking (BLANK_LEADING=1): each digit above the most significant nonzero digit drives seg=7'h7F; digit 0 is never blanked, so value 0 shows "0".
REQ-027 dp output is the inverse of the committed dp bit for the active digit; it is shown even on blanked digits.
REQ-028 seg, dp and an are registered, one cycle behind the index and counter.
REQ-029 The scan continues uninterrupted during CONVERT and shows the previous committed value; no partial value is ever displayed.

Reset
REQ-030 Reset clears: FSM to IDLE, scan counter and index to 0, display register to 0, dp bits to 0, overflow=0, ready=1.
REQ-031 While reset=1: an=8'hFF, seg=7'h7F, dp=1.
REQ-032 Reset asserted during CONVERT aborts the conversion; the display register shows 0 after reset and the aborted value is never committed.

Verification
REQ-033 Load 16'd359, BLANK_LEADING=1, NUM_DIGITS=8 -> after 18 cycles, slots 0/1/2 show 9/5/3 (seg 0010000/0010010/0110000), slots 3-7 show 7'h7F, overflow=0.
REQ-034 NUM_DIGITS=3, load 16'd1000 -> overflow=1, all three slots show 7'b0111111, an[7:3]=1 throughout.
REQ-035 Load 0 -> slot 0 shows 7'b1000000 and slots 1-7 are blank; with BLANK_LEADING=0, all 8 slots show 7'b1000000.
REQ-036 Pulse value_valid with 123 and, 5 cycles later, with 456 -> the second strobe is ignored (ready=0), the display shows 123, and ready returns to 1 at cycle 18.
REQ-037 REFRESH_BITS=4, GHOST_CYCLES=2 -> each anode is low for exactly 14 of every 16 cycles, the index sequence is 0..7 then 0, and no two anodes are ever low simultaneously.
REQ-038 Assert reset 8 cycles into the conversion of 999 -> an=8'hFF during reset; afterwards the display shows "0", ready=1 and overflow=0.
